// File: rtl/noc_inport_handshake_adapter_pkg.sv
// Shared NoC definitions for the injection-side handshake adapter:
// occupancy encodings, the FIFO read latency, and the read-issue rule.
package noc_inport_handshake_adapter_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // Standard-mode native FIFO: dout is valid one cycle after rd_en.
  localparam int unsigned FIFO_RD_LAT = 1;

  // A new read may be issued only if, after this cycle's accept, the stored
  // flits plus the one already in flight leave room for one more arrival.
  function automatic logic rd_permitted(occ_state_e occ, logic inflight, logic accept);
    logic [2:0] load;
    load = {1'b0, occ} + {2'b00, inflight} - {2'b00, accept};
    return (load <= 3'd1);
  endfunction

endpackage

// File: rtl/noc_inport_handshake_adapter_if.sv
// FIFO-read / NoC-local-input signal bundle. The slave view is the adapter.
interface noc_inport_handshake_adapter_if #(
  parameter int DataWidth = 64
);

  logic [DataWidth-1:0] fifo_data_i;
  logic                 fifo_empty_i;
  logic                 fifo_rd_en_o;
  logic [DataWidth-1:0] data_o;
  logic                 data_valid_o;
  logic                 avail_i;
  logic                 idle_o;

  modport slave (
    input  fifo_data_i, fifo_empty_i, avail_i,
    output fifo_rd_en_o, data_o, data_valid_o, idle_o
  );

  modport master (
    output fifo_data_i, fifo_empty_i, avail_i,
    input  fifo_rd_en_o, data_o, data_valid_o, idle_o
  );

endinterface

// File: rtl/noc_inport_handshake_adapter.sv
// Drains a latency-1 native FIFO into a NoC local input port. A head/skid
// pair absorbs the word already in flight when avail drops, so flits are
// never lost or duplicated and full rate is kept while avail stays high.
module noc_inport_handshake_adapter
  import noc_inport_handshake_adapter_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input logic clk,
  input logic rst,
  noc_inport_handshake_adapter_if.slave bus
);

  occ_state_e           occ_q;
  logic                 inflight_p0;
  logic [DataWidth-1:0] head_p1;
  logic [DataWidth-1:0] skid_p1;
  logic                 vld_p1;
  logic                 accept;
  logic                 arrival;
  logic                 rd_en;

  assign vld_p1  = (occ_q != OCC_EMPTY);
  assign accept  = vld_p1 & bus.avail_i;
  assign arrival = inflight_p0;
  assign rd_en   = ~rst & ~bus.fifo_empty_i & rd_permitted(occ_q, inflight_p0, accept);

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.data_o       = head_p1;
  assign bus.data_valid_o = vld_p1;
  assign bus.idle_o       = (occ_q == OCC_EMPTY) & ~inflight_p0;

  // Occupancy FSM and in-flight tracking (stage p0: read issued, data at FIFO dout)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      inflight_p0 <= 1'b0;
    end else begin
      inflight_p0 <= rd_en;
      case (occ_q)
        OCC_EMPTY: if (arrival) occ_q <= OCC_ONE;
        OCC_ONE: begin
          if (accept && !arrival)      occ_q <= OCC_EMPTY;
          else if (!accept && arrival) occ_q <= OCC_TWO;
        end
        OCC_TWO:   if (accept) occ_q <= OCC_ONE;
        default:   occ_q <= OCC_EMPTY;
      endcase
    end
  end

  // Head/skid data routing (stage p1: stored flits); data is not reset
  always_ff @(posedge clk) begin
    case (occ_q)
      OCC_EMPTY: if (arrival) head_p1 <= bus.fifo_data_i;
      OCC_ONE: begin
        if (arrival) begin
          if (accept) head_p1 <= bus.fifo_data_i;
          else        skid_p1 <= bus.fifo_data_i;
        end
      end
      OCC_TWO:   if (accept) head_p1 <= skid_p1;
      default: ;
    endcase
  end

  // The read rule must keep arrivals out of the full state.
  a_no_arrival_in_two: assert property (@(posedge clk) disable iff (rst)
    !((occ_q == OCC_TWO) && inflight_p0));

endmodule

// File: tb/tb_noc_inport_handshake_adapter.sv
// Bench for noc_inport_handshake_adapter (DataWidth=8) with a latency-1 FIFO
// model, per-cycle vector tables, directed corner sequences and a random run.
module tb_noc_inport_handshake_adapter;

  logic clk;
  logic rst;
  logic fifo_flush;

  noc_inport_handshake_adapter_if #(.DataWidth(8)) bif ();

  noc_inport_handshake_adapter #(.DataWidth(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: every word ever pushed stays in mem, so mem also serves as
  // the expected delivery order.
  logic [7:0] mem [0:16383];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bif.fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (bif.fifo_rd_en_o) begin
      bif.fifo_data_i <= mem[rd_ptr[13:0]];
      rd_ptr          <= rd_ptr + 1;
    end else begin
      bif.fifo_data_i <= 8'($urandom);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[13:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard state, owned by the main process.
  int         exp_idx = 0;
  int         outstanding = 0;
  logic       hold_q = 1'b0;
  logic [7:0] held_data = 8'h00;

  // Called at the negedge: checks delivery order, backpressure stability,
  // the 2-entry bound and reads on empty, then advances the scoreboard.
  task automatic mon_check();
    logic acc;
    if (rst) begin
      exp_idx     = rd_ptr;
      outstanding = 0;
      hold_q      = 1'b0;
      return;
    end
    acc = bif.data_valid_o & bif.avail_i;
    chk("occ_bound", 32'((outstanding + int'(bif.fifo_rd_en_o) - int'(acc)) <= 2), 32'd1);
    chk("rd_on_empty", 32'(bif.fifo_rd_en_o & bif.fifo_empty_i), 32'd0);
    if (hold_q) begin
      chk("hold_vld", 32'(bif.data_valid_o), 32'd1);
      chk("hold_data", 32'(bif.data_o), 32'(held_data));
    end
    if (acc) begin
      chk("order", 32'(bif.data_o), 32'(mem[exp_idx[13:0]]));
      exp_idx++;
    end
    outstanding = outstanding + int'(bif.fifo_rd_en_o) - int'(acc);
    hold_q      = bif.data_valid_o & ~bif.avail_i;
    held_data   = bif.data_o;
  endtask

  typedef struct {
    logic       avail;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_rd;
    logic       exp_idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a, logic v, logic [7:0] d, logic r, logic i);
    vec_t x;
    x.avail = a; x.exp_vld = v; x.exp_data = d; x.exp_rd = r; x.exp_idle = i;
    return x;
  endfunction

  // Applies one table row per cycle, starting at posedge+1.
  task automatic run_tbl(input string name);
    foreach (tbl[k]) begin
      bif.avail_i = tbl[k].avail;
      @(negedge clk);
      mon_check();
      chk({name, "_vld"}, 32'(bif.data_valid_o), 32'(tbl[k].exp_vld));
      chk({name, "_rd"}, 32'(bif.fifo_rd_en_o), 32'(tbl[k].exp_rd));
      chk({name, "_idle"}, 32'(bif.idle_o), 32'(tbl[k].exp_idle));
      if (tbl[k].exp_vld) chk({name, "_data"}, 32'(bif.data_o), 32'(tbl[k].exp_data));
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bif.avail_i = 1'b1;
    while (!(bif.idle_o && bif.fifo_empty_i) && n < budget) begin
      @(negedge clk);
      mon_check();
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(bif.idle_o & bif.fifo_empty_i), 32'd1);
    chk("all_delivered", 32'(exp_idx), 32'(wr_ptr));
  endtask

  initial begin
    int start;
    rst = 1'b1;
    fifo_flush = 1'b0;
    bif.avail_i = 1'b0;

    // Reset values, including no read while the FIFO holds data under reset
    repeat (2) begin
      @(negedge clk);
      mon_check();
      chk("rst_vld", 32'(bif.data_valid_o), 32'd0);
      chk("rst_rd", 32'(bif.fifo_rd_en_o), 32'd0);
      chk("rst_idle", 32'(bif.idle_o), 32'd1);
    end
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    mon_check();
    chk("rst_rd_nonempty", 32'(bif.fifo_rd_en_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three words, avail held high
    tbl.push_back(mk(1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'h11, 1, 0));
    tbl.push_back(mk(1, 1, 8'h22, 0, 0));
    tbl.push_back(mk(1, 1, 8'h33, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1));
    run_tbl("three");

    // 0x01..0x08 with avail low for 3 cycles after 0x02 is accepted
    for (int v = 1; v <= 8; v++) push(8'(v));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'h01, 1, 0));
    tbl.push_back(mk(1, 1, 8'h02, 1, 0));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0));
    tbl.push_back(mk(1, 1, 8'h03, 1, 0));
    tbl.push_back(mk(1, 1, 8'h04, 1, 0));
    tbl.push_back(mk(1, 1, 8'h05, 1, 0));
    tbl.push_back(mk(1, 1, 8'h06, 1, 0));
    tbl.push_back(mk(1, 1, 8'h07, 0, 0));
    tbl.push_back(mk(1, 1, 8'h08, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1));
    run_tbl("stall");

    // FIFO goes empty with the last word in flight
    push(8'hAA);
    tbl.push_back(mk(1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 8'hAA, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1));
    run_tbl("last");

    // Alternating avail over 16 flits
    for (int v = 0; v < 16; v++) push(8'(v));
    start = exp_idx;
    for (int i = 0; i < 80 && exp_idx < start + 16; i++) begin
      bif.avail_i = (i % 2 == 0);
      @(negedge clk);
      mon_check();
      @(posedge clk); #1;
    end
    chk("alt_count", 32'(exp_idx - start), 32'd16);
    drain(20);

    // Asynchronous reset while two flits are stored
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    bif.avail_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      mon_check();
      @(posedge clk); #1;
    end
    @(negedge clk);
    mon_check();
    chk("two_rd_off", 32'(bif.fifo_rd_en_o), 32'd0);
    chk("two_head", 32'(bif.data_o), 32'h51);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(bif.data_valid_o), 32'd0);
    chk("arst_rd", 32'(bif.fifo_rd_en_o), 32'd0);
    chk("arst_idle", 32'(bif.idle_o), 32'd1);
    fifo_flush = 1'b1;
    @(negedge clk);
    mon_check();
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    @(negedge clk);
    mon_check();
    @(posedge clk); #1;
    rst = 1'b0;
    bif.avail_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      mon_check();
      chk("post_rst_vld", 32'(bif.data_valid_o), 32'd0);
      chk("post_rst_rd", 32'(bif.fifo_rd_en_o), 32'd0);
      chk("post_rst_idle", 32'(bif.idle_o), 32'd1);
      @(posedge clk); #1;
    end

    // Random avail and FIFO refill
    for (int i = 0; i < 10000; i++) begin
      bif.avail_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) push(8'($urandom));
      @(negedge clk);
      mon_check();
      @(posedge clk); #1;
    end
    drain(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
